mem_arbiter: RTL and testbench

Shares the single data-memory port (1-cycle combinational read, posedge-committed masked write, op encoding 000/001/010/100/101) between the instruction-fetch unit (IFU) and the load/store unit (LSU). Each requester gets a valid/ready request channel and a one-cycle response pulse. The block owns the memory control signals, inserts a programmable access latency, and rejects misaligned accesses before they reach memory. It sits between the core's IFU/LSU and the memory wrapper.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared definitions: memory op codes, FSM states, owner ids
// and the op normalisation / misalignment helpers.
package mem_arb_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Owner ids double as bit positions in the one-hot grant vector.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Unused op encodings behave as a word access.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        case (op)
            OP_B, OP_H, OP_W, OP_BU, OP_HU: return op;
            default:                        return OP_W;
        endcase
    endfunction

    // A halfword only faults when it would straddle a word boundary.
    function automatic logic misaligned(input logic [2:0] op,
                                        input logic [1:0] a);
        case (op)
            OP_H, OP_HU: return a == 2'b11;
            OP_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between IFU and LSU.
// Ports: ifu_valid_i, lsu_valid_i, ptr_i (MEM_ARB_RR_EN only; 1 favours
// LSU), gnt_o one-hot indexed by OWN_IFU / OWN_LSU.
// MEM_ARB_RR_EN defined: round-robin on contention; otherwise LSU wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid_i,
    input  logic       lsu_valid_i,
`ifdef MEM_ARB_RR_EN
    input  logic       ptr_i,
`endif
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (ifu_valid_i && lsu_valid_i) begin
`ifdef MEM_ARB_RR_EN
            if (ptr_i) gnt_o[OWN_LSU] = 1'b1;
            else       gnt_o[OWN_IFU] = 1'b1;
`else
            gnt_o[OWN_LSU] = 1'b1;
`endif
        end else if (lsu_valid_i) begin
            gnt_o[OWN_LSU] = 1'b1;
        end else if (ifu_valid_i) begin
            gnt_o[OWN_IFU] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between IFU and LSU with a
// programmable access latency and misalignment rejection.
// Ports: clk_i, rst_i (sync, active high); ifu_* / lsu_* valid-ready
// request channels with one-cycle resp pulses; resp_rdata_o shared;
// mem_* drives the memory wrapper, mem_rdata_i is combinational.
// Parameter LATENCY (1..15): BUSY cycles before memory is touched.
// Macro MEM_ARB_RR_EN selects round-robin instead of LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ifu_valid_i,
    output logic        ifu_ready_o,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_resp_valid_o,
    output logic        ifu_resp_err_o,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_wen_i,
    input  logic [2:0]  lsu_op_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [2:0]  mem_op_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  op_q, op_d;
    logic        wen_q, wen_d;
    logic        own_q, own_d;
    logic        err_q, err_d;
    logic [1:0]  gnt;
`ifdef MEM_ARB_RR_EN
    logic        ptr_q, ptr_d;
`endif

    mem_arb_pick u_pick (
        .ifu_valid_i (ifu_valid_i),
        .lsu_valid_i (lsu_valid_i),
`ifdef MEM_ARB_RR_EN
        .ptr_i       (ptr_q),
`endif
        .gnt_o       (gnt)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        op_d             = op_q;
        wen_d            = wen_q;
        own_d            = own_q;
        err_d            = err_q;
`ifdef MEM_ARB_RR_EN
        ptr_d            = ptr_q;
`endif
        ifu_ready_o      = 1'b0;
        lsu_ready_o      = 1'b0;
        ifu_resp_valid_o = 1'b0;
        ifu_resp_err_o   = 1'b0;
        lsu_resp_valid_o = 1'b0;
        lsu_resp_err_o   = 1'b0;
        resp_rdata_o     = 32'h0;
        mem_addr_o       = 32'h0;
        mem_rd_en_o      = 1'b0;
        mem_wr_en_o      = 1'b0;
        mem_op_o         = 3'b000;
        mem_wdata_o      = 32'h0;

        unique case (state_q)
            IDLE: begin
                // A handshake during reset would be lost, so hide ready.
                ifu_ready_o = gnt[OWN_IFU] & ~rst_i;
                lsu_ready_o = gnt[OWN_LSU] & ~rst_i;
                if (|gnt) begin
                    if (gnt[OWN_LSU]) begin
                        own_d   = OWN_LSU;
                        addr_d  = lsu_addr_i;
                        op_d    = norm_op(lsu_op_i);
                        wen_d   = lsu_wen_i;
                        wdata_d = lsu_wdata_i;
                    end else begin
                        own_d   = OWN_IFU;
                        addr_d  = ifu_addr_i;
                        op_d    = OP_W;
                        wen_d   = 1'b0;
                        wdata_d = 32'h0;
                    end
                    err_d   = misaligned(op_d, addr_d[1:0]);
                    rdata_d = 32'h0;
                    cnt_d   = CNT_INIT;
                    state_d = err_d ? RESP : BUSY;
`ifdef MEM_ARB_RR_EN
                    // Favour whoever did not just win.
                    ptr_d   = gnt[OWN_IFU];
`endif
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    mem_rd_en_o = ~wen_q;
                    // A store must not commit while reset is discarding it.
                    mem_wr_en_o = wen_q & ~rst_i;
                    if (mem_rd_en_o || mem_wr_en_o) begin
                        mem_addr_o  = addr_q;
                        mem_op_o    = op_q;
                        mem_wdata_o = wdata_q;
                    end
                    if (!wen_q) rdata_d = mem_rdata_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!rst_i) begin
                    resp_rdata_o = rdata_q;
                    if (own_q == OWN_LSU) begin
                        lsu_resp_valid_o = 1'b1;
                        lsu_resp_err_o   = err_q;
                    end else begin
                        ifu_resp_valid_o = 1'b1;
                        ifu_resp_err_o   = err_q;
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            op_q    <= 3'b000;
            wen_q   <= 1'b0;
            own_q   <= OWN_IFU;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
            own_q   <= own_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: timestamp-based transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_valid = 1'b0;
    logic        ifu_ready;
    logic [31:0] ifu_addr = 32'h0;
    logic        ifu_rv, ifu_err;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [31:0] lsu_addr = 32'h0;
    logic        lsu_wen = 1'b0;
    logic [2:0]  lsu_op = 3'b000;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_rv, lsu_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [2:0]  mem_op;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    assign mem_rdata = memf(mem_addr);

    mem_arbiter #(.LATENCY(L)) dut (
        .clk_i(clk), .rst_i(rst),
        .ifu_valid_i(ifu_valid), .ifu_ready_o(ifu_ready),
        .ifu_addr_i(ifu_addr),
        .ifu_resp_valid_o(ifu_rv), .ifu_resp_err_o(ifu_err),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready),
        .lsu_addr_i(lsu_addr), .lsu_wen_i(lsu_wen),
        .lsu_op_i(lsu_op), .lsu_wdata_i(lsu_wdata),
        .lsu_resp_valid_o(lsu_rv), .lsu_resp_err_o(lsu_err),
        .resp_rdata_o(resp_rdata),
        .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en),
        .mem_wr_en_o(mem_wr_en), .mem_op_o(mem_op),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Spec rules, written independently of the RTL.
    function automatic logic [2:0] nop(input logic [2:0] op);
        if (op == 3'b011 || op == 3'b110 || op == 3'b111) return 3'b010;
        return op;
    endfunction

    function automatic logic mis(input logic [2:0] op, input logic [1:0] a);
        if ((op == 3'b001 || op == 3'b101) && a == 2'b11) return 1'b1;
        if (op == 3'b010 && a != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

`ifdef MEM_ARB_RR_EN
    bit fav = 1'b0;   // 1: LSU wins the next contention
`endif

    // 0 none, 1 IFU, 2 LSU
    function automatic int win(input logic iv, input logic lv);
        if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
            return fav ? 2 : 1;
`else
            return 2;
`endif
        end
        if (lv) return 2;
        if (iv) return 1;
        return 0;
    endfunction

    // monitor record
    int          en_cyc = 0, rd_cnt = 0, wr_cnt = 0;
    int          resp_cnt = 0, resp_cyc = 0;
    logic [31:0] en_addr = 0, en_wdata = 0, resp_data = 0;
    logic [2:0]  en_op = 0;
    logic        resp_err = 0, resp_own = 0;

    // model: one transaction in flight, described by its handshake cycle
    bit          inf = 1'b0;
    int          t_hs = 0;
    logic        t_own = 0, t_wen = 0, t_err = 0;
    logic [31:0] t_addr = 0, t_wd = 0, t_rd = 0;
    logic [2:0]  t_op = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : p_model
        logic        e_ir, e_lr, e_rd, e_wr, e_iv, e_ie, e_lv, e_le;
        logic [2:0]  e_op;
        logic [31:0] e_a, e_wd, e_rdat;
        int          w, d, rc;
        e_ir = 0; e_lr = 0; e_rd = 0; e_wr = 0;
        e_iv = 0; e_ie = 0; e_lv = 0; e_le = 0;
        e_op = 0; e_a = 0; e_wd = 0; e_rdat = 0;
        w = 0; d = 0; rc = 0;
        if (!inf) begin
            if (!rst) begin
                w = win(ifu_valid, lsu_valid);
                e_ir = (w == 1);
                e_lr = (w == 2);
            end
        end else begin
            d  = cyc - t_hs;
            rc = t_err ? 1 : L + 1;
            if (!t_err && d == L) begin
                e_rd = !t_wen;
                e_wr = t_wen && !rst;
                if (e_rd || e_wr) begin
                    e_a = t_addr; e_op = t_op; e_wd = t_wd;
                end
            end
            if (d == rc && !rst) begin
                e_rdat = t_rd;
                if (t_own) begin e_lv = 1; e_le = t_err; end
                else       begin e_iv = 1; e_ie = t_err; end
            end
        end

        if (mem_rd_en || mem_wr_en) begin
            en_cyc = cyc; en_addr = mem_addr;
            en_op = mem_op; en_wdata = mem_wdata;
        end
        if (mem_rd_en) rd_cnt++;
        if (mem_wr_en) wr_cnt++;
        if (ifu_rv || lsu_rv) begin
            resp_cnt++; resp_cyc = cyc; resp_data = resp_rdata;
            resp_own = lsu_rv; resp_err = lsu_rv ? lsu_err : ifu_err;
        end

        if (chk_en) begin
            chk("ready", 128'({ifu_ready, lsu_ready}), 128'({e_ir, e_lr}));
            chk("mem port",
                128'({mem_rd_en, mem_wr_en, mem_op, mem_addr, mem_wdata}),
                128'({e_rd, e_wr, e_op, e_a, e_wd}));
            chk("response",
                128'({ifu_rv, ifu_err, lsu_rv, lsu_err, resp_rdata}),
                128'({e_iv, e_ie, e_lv, e_le, e_rdat}));
        end

        if (rst) begin
            inf = 0;
`ifdef MEM_ARB_RR_EN
            fav = 0;
`endif
        end else if (inf) begin
            if (d == rc) inf = 0;
        end else if (w != 0) begin
            inf = 1; t_hs = cyc;
            if (w == 2) begin
                t_own = 1; t_addr = lsu_addr; t_op = nop(lsu_op);
                t_wen = lsu_wen; t_wd = lsu_wdata;
            end else begin
                t_own = 0; t_addr = ifu_addr; t_op = 3'b010;
                t_wen = 0; t_wd = 0;
            end
            t_err = mis(t_op, t_addr[1:0]);
            t_rd  = (!t_err && !t_wen) ? memf(t_addr) : 32'h0;
`ifdef MEM_ARB_RR_EN
            fav = (w == 1);
`endif
        end
    end

    task automatic wait_ready(input bit lsu, output int hs);
        hs = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); #1;
            if (lsu ? lsu_ready : ifu_ready) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) chk("handshake timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_resp(input int n0, output int rc);
        rc = -1;
        for (int n = 0; n < 40; n++) begin
            if (resp_cnt > n0) begin
                rc = resp_cyc;
                break;
            end
            @(negedge clk); #1;
        end
        if (rc < 0) chk("response timeout", 128'(0), 128'(1));
    endtask

    task automatic lsu_txn(input logic [31:0] a, input logic w,
                           input logic [2:0] op, input logic [31:0] wd,
                           output int hs, output int rc);
        int n0;
        @(posedge clk); #1;
        n0 = resp_cnt;
        lsu_addr = a; lsu_wen = w; lsu_op = op; lsu_wdata = wd;
        lsu_valid = 1;
        wait_ready(1, hs);
        @(posedge clk); #1;
        lsu_valid = 0;
        wait_resp(n0, rc);
    endtask

    task automatic ifu_txn(input logic [31:0] a, output int hs,
                           output int rc);
        int n0;
        @(posedge clk); #1;
        n0 = resp_cnt;
        ifu_addr = a; ifu_valid = 1;
        wait_ready(0, hs);
        @(posedge clk); #1;
        ifu_valid = 0;
        wait_resp(n0, rc);
    endtask

    initial begin
        int hs, rc, c0, n0, w0;
        int g[4];
        int h[4];
        int eg[4];
        bit found;

        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk); #1;
        chk("reset outputs",
            128'({ifu_ready, lsu_ready, ifu_rv, ifu_err, lsu_rv, lsu_err,
                  mem_rd_en, mem_wr_en, mem_op, mem_addr, mem_wdata,
                  resp_rdata}), 128'(0));
        @(posedge clk); #1;
        rst = 0;

        c0 = rd_cnt;
        lsu_txn(32'h100, 0, 3'b010, 32'h11111111, hs, rc);
        chk("load enable delay", 128'(en_cyc - hs), 128'(3));
        chk("load resp delay", 128'(rc - hs), 128'(4));
        chk("load rdata", 128'(resp_data), 128'(32'hDEADBEEF));
        chk("load rd_en count", 128'(rd_cnt - c0), 128'(1));
        chk("load owner/err", 128'({resp_own, resp_err}), 128'(2'b10));

        w0 = wr_cnt;
        lsu_txn(32'h203, 1, 3'b000, 32'hAB, hs, rc);
        chk("store wr_en count", 128'(wr_cnt - w0), 128'(1));
        chk("store enable delay", 128'(en_cyc - hs), 128'(3));
        chk("store mem addr/op/data",
            128'({en_addr, en_op, en_wdata}),
            128'({32'h203, 3'b000, 32'hAB}));
        chk("store rdata", 128'(resp_data), 128'(0));

        c0 = rd_cnt + wr_cnt;
        ifu_txn(32'h102, hs, rc);
        repeat (3) @(posedge clk);
        chk("ifu misaligned delay", 128'(rc - hs), 128'(1));
        chk("ifu misaligned owner/err",
            128'({resp_own, resp_err}), 128'(2'b01));
        chk("ifu misaligned no enable", 128'(rd_cnt + wr_cnt - c0), 128'(0));

        ifu_txn(32'h40, hs, rc);
        chk("ifu fetch delay", 128'(rc - hs), 128'(4));
        chk("ifu fetch err", 128'(resp_err), 128'(0));

        lsu_txn(32'h103, 0, 3'b001, 32'h0, hs, rc);
        chk("lh @..11 err", 128'({resp_err, rc - hs}), 128'({1'b1, 32'd1}));
        lsu_txn(32'h101, 0, 3'b001, 32'h0, hs, rc);
        chk("lh @..01 ok", 128'({resp_err, rc - hs}), 128'({1'b0, 32'd4}));
        lsu_txn(32'h102, 0, 3'b101, 32'h0, hs, rc);
        chk("lhu @..10 ok", 128'(resp_err), 128'(0));
        lsu_txn(32'h102, 0, 3'b111, 32'h0, hs, rc);
        chk("op 111 as word err", 128'(resp_err), 128'(1));
        // last lone grant is LSU, so round-robin now favours IFU
        lsu_txn(32'h104, 0, 3'b110, 32'h0, hs, rc);
        chk("op 110 as word", 128'({resp_err, en_op}), 128'({1'b0, 3'b010}));

        @(posedge clk); #1;
        lsu_addr = 32'h200; lsu_wen = 0; lsu_op = 3'b010;
        lsu_wdata = 32'h0; ifu_addr = 32'h300;
        lsu_valid = 1; ifu_valid = 1;
        for (int gi = 0; gi < 4; gi++) begin
            found = 0;
            g[gi] = 0; h[gi] = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk); #1;
                if (ifu_ready || lsu_ready) begin
                    g[gi] = lsu_ready ? 2 : 1;
                    h[gi] = cyc;
                    found = 1;
                    break;
                end
            end
            if (!found) chk("contention timeout", 128'(0), 128'(1));
        end
        @(posedge clk); #1;
        lsu_valid = 0; ifu_valid = 0;
`ifdef MEM_ARB_RR_EN
        eg = '{1, 2, 1, 2};
`else
        eg = '{2, 2, 2, 2};
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("grant %0d owner", i), 128'(g[i]), 128'(eg[i]));
            if (i > 0)
                chk($sformatf("grant %0d spacing", i),
                    128'(h[i] - h[i-1]), 128'(5));
        end
        repeat (8) @(posedge clk);

        #1;
        n0 = resp_cnt; w0 = wr_cnt;
        lsu_addr = 32'h208; lsu_wen = 1; lsu_op = 3'b010;
        lsu_wdata = 32'h12345678; lsu_valid = 1;
        wait_ready(1, hs);
        @(posedge clk); #1;
        lsu_valid = 0; ifu_addr = 32'h44; ifu_valid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk); #1;
        chk("rst in enable: wr_en", 128'(mem_wr_en), 128'(0));
        chk("rst in enable: ifu_ready", 128'(ifu_ready), 128'(0));
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
        chk("ready after rst", 128'(ifu_ready), 128'(1));
        @(posedge clk); #1;
        ifu_valid = 0;
        repeat (8) @(posedge clk);
        chk("rst store not committed", 128'(wr_cnt - w0), 128'(0));
        chk("rst drops response", 128'(resp_cnt - n0), 128'(1));
        chk("post-rst response owner", 128'(resp_own), 128'(0));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
